// File: rtl/wide_reorder_buffer_pkg.sv
// Shared types for the reorder buffer: entry layout, tag type and register-address widths.
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif
`ifndef NUM_S_REG
`define NUM_S_REG 16
`endif

package wide_reorder_buffer_pkg;
  localparam int RW_ADDR_W = $clog2(`NUM_D_REG);
  localparam int RS_ADDR_W = $clog2(`NUM_S_REG);
  localparam int ROB_DEPTH = 16;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                 valid;
    logic                 done;
    logic                 use_rw;
    logic [RW_ADDR_W-1:0] rw_addr;
    logic                 use_rs;
    logic [RS_ADDR_W-1:0] rs_addr;
  } rob_entry_t;
endpackage

// File: rtl/wide_reorder_buffer_if.sv
// Dispatch, writeback, commit and status bundle between the core pipeline and the ROB.
interface wide_reorder_buffer_if #(
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 2,
  parameter int TAG_W      = 4
);
  import wide_reorder_buffer_pkg::*;

  logic                                  flush;
  logic [DISPATCH_W-1:0]                 disp_valid;
  logic [DISPATCH_W-1:0]                 disp_use_rw;
  logic [DISPATCH_W-1:0]                 disp_use_rs;
  logic [DISPATCH_W-1:0][RW_ADDR_W-1:0]  disp_rw_addr;
  logic [DISPATCH_W-1:0][RS_ADDR_W-1:0]  disp_rs_addr;
  logic                                  disp_ready;
  logic [DISPATCH_W-1:0][TAG_W-1:0]      disp_tag;
  logic [WB_PORTS-1:0]                   wb_valid;
  logic [WB_PORTS-1:0][TAG_W-1:0]        wb_tag;
  logic [COMMIT_W-1:0]                   commit_valid;
  logic [COMMIT_W-1:0]                   commit_use_rw;
  logic [COMMIT_W-1:0]                   commit_use_rs;
  logic [COMMIT_W-1:0][RW_ADDR_W-1:0]    commit_rw_addr;
  logic [COMMIT_W-1:0][RS_ADDR_W-1:0]    commit_rs_addr;
  logic [COMMIT_W-1:0][TAG_W-1:0]        commit_tag;
  logic [TAG_W:0]                        count;
  logic                                  empty;
  logic                                  full;

  modport master (
    output flush, disp_valid, disp_use_rw, disp_use_rs, disp_rw_addr, disp_rs_addr,
           wb_valid, wb_tag,
    input  disp_ready, disp_tag, commit_valid, commit_use_rw, commit_use_rs,
           commit_rw_addr, commit_rs_addr, commit_tag, count, empty, full
  );

  modport slave (
    input  flush, disp_valid, disp_use_rw, disp_use_rs, disp_rw_addr, disp_rs_addr,
           wb_valid, wb_tag,
    output disp_ready, disp_tag, commit_valid, commit_use_rw, commit_use_rs,
           commit_rw_addr, commit_rs_addr, commit_tag, count, empty, full
  );
endinterface

// File: rtl/wide_reorder_buffer_lane_alloc.sv
// Prefix popcount: each lane's offset is the number of requesting lanes below it.
module rob_lane_alloc #(
  parameter int LANES = 2,
  localparam int CNT_W = $clog2(LANES + 1)
) (
  input  logic [LANES-1:0]            req,
  output logic [LANES-1:0][CNT_W-1:0] offset,
  output logic [CNT_W-1:0]            total
);
  logic [CNT_W-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < LANES; i++) begin
      offset[i] = acc;
      acc = acc + CNT_W'(req[i]);
    end
  end

  assign total = acc;
endmodule

// File: rtl/wide_reorder_buffer.sv
// Superscalar reorder buffer: in-order multi-lane dispatch, tagged writeback, prefix commit from head.
module wide_reorder_buffer
  import wide_reorder_buffer_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 2,
  parameter int TAG_W      = $clog2(DEPTH)
) (
  input logic                  clk,
  input logic                  n_rst,
  wide_reorder_buffer_if.slave bus
);
  localparam int DCNT_W = $clog2(DISPATCH_W + 1);
  localparam int CCNT_W = $clog2(COMMIT_W + 1);

  rob_entry_t mem [DEPTH];
  logic [TAG_W-1:0] head, tail;
  logic [TAG_W:0]   count;

  logic [DISPATCH_W-1:0][DCNT_W-1:0] disp_off;
  logic [DCNT_W-1:0]                 disp_total;
  logic [COMMIT_W-1:0][CCNT_W-1:0]   cmt_off;
  logic [CCNT_W-1:0]                 cmt_total;
  logic [COMMIT_W-1:0]               cmt_run;
  logic [COMMIT_W-1:0][TAG_W-1:0]    cmt_slot;
  logic                              run;
  logic                              do_disp;
  logic [DCNT_W-1:0]                 n_disp;

  rob_lane_alloc #(.LANES(DISPATCH_W)) u_disp_alloc (
    .req(bus.disp_valid), .offset(disp_off), .total(disp_total)
  );

  rob_lane_alloc #(.LANES(COMMIT_W)) u_cmt_alloc (
    .req(cmt_run), .offset(cmt_off), .total(cmt_total)
  );

  // Readiness looks only at registered occupancy, so same-cycle commits never widen it.
  assign bus.disp_ready = ({1'b0, count} + (TAG_W+2)'(DISPATCH_W)) <= (TAG_W+2)'(DEPTH);
  assign do_disp        = bus.disp_ready && !bus.flush;
  assign n_disp         = do_disp ? disp_total : '0;
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.full       = (count == (TAG_W+1)'(DEPTH));

  // Idle lanes report tail+lane so the tag vector is deterministic when nothing dispatches.
  always_comb begin
    for (int i = 0; i < DISPATCH_W; i++)
      bus.disp_tag[i] = tail + TAG_W'(bus.disp_valid[i] ? disp_off[i] : DCNT_W'(i));
  end

  always_comb begin
    run = !bus.flush;
    for (int k = 0; k < COMMIT_W; k++) begin
      run = run && mem[head + TAG_W'(k)].valid && mem[head + TAG_W'(k)].done;
      cmt_run[k] = run;
    end
  end

  always_comb begin
    for (int k = 0; k < COMMIT_W; k++) begin
      cmt_slot[k]           = head + TAG_W'(cmt_run[k] ? cmt_off[k] : CCNT_W'(k));
      bus.commit_tag[k]     = cmt_slot[k];
      bus.commit_use_rw[k]  = mem[cmt_slot[k]].use_rw;
      bus.commit_rw_addr[k] = mem[cmt_slot[k]].rw_addr;
      bus.commit_use_rs[k]  = mem[cmt_slot[k]].use_rs;
      bus.commit_rs_addr[k] = mem[cmt_slot[k]].rs_addr;
    end
    bus.commit_valid = cmt_run;
  end

  always_ff @(posedge clk) begin
    if (!n_rst || bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i].valid <= 1'b0;
        mem[i].done  <= 1'b0;
      end
    end else begin
      for (int p = 0; p < WB_PORTS; p++)
        if (bus.wb_valid[p] && mem[bus.wb_tag[p]].valid)
          mem[bus.wb_tag[p]].done <= 1'b1;
      for (int k = 0; k < COMMIT_W; k++)
        if (cmt_run[k]) begin
          mem[cmt_slot[k]].valid <= 1'b0;
          mem[cmt_slot[k]].done  <= 1'b0;
        end
      // Dispatch only targets free slots, so it never collides with a retiring entry.
      for (int i = 0; i < DISPATCH_W; i++)
        if (do_disp && bus.disp_valid[i])
          mem[bus.disp_tag[i]] <= '{valid:   1'b1,
                                    done:    1'b0,
                                    use_rw:  bus.disp_use_rw[i],
                                    rw_addr: bus.disp_rw_addr[i],
                                    use_rs:  bus.disp_use_rs[i],
                                    rs_addr: bus.disp_rs_addr[i]};
      head  <= head + TAG_W'(cmt_total);
      tail  <= tail + TAG_W'(n_disp);
      count <= count + (TAG_W+1)'(n_disp) - (TAG_W+1)'(cmt_total);
    end
  end
endmodule

// File: tb/tb_wide_reorder_buffer.sv
// Directed bench for the reorder buffer at DEPTH=8, two lanes each way.
module tb_wide_reorder_buffer;
  import wide_reorder_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 2;
  localparam int CW    = 2;
  localparam int WB    = 2;
  localparam int TW    = 3;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  wide_reorder_buffer_if #(.DISPATCH_W(DW), .COMMIT_W(CW), .WB_PORTS(WB), .TAG_W(TW)) bus ();

  wide_reorder_buffer #(
    .DEPTH(DEPTH), .DISPATCH_W(DW), .COMMIT_W(CW), .WB_PORTS(WB), .TAG_W(TW)
  ) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.flush        = 1'b0;
    bus.disp_valid   = '0;
    bus.disp_use_rw  = '0;
    bus.disp_use_rs  = '0;
    bus.disp_rw_addr = '0;
    bus.disp_rs_addr = '0;
    bus.wb_valid     = '0;
    bus.wb_tag       = '0;
  endtask

  task automatic wb(input logic [1:0] v, input int t0, input int t1);
    bus.wb_valid  = v;
    bus.wb_tag[0] = TW'(t0);
    bus.wb_tag[1] = TW'(t1);
  endtask

  initial begin
    clr();
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    #1;
    check_val("rst_ready", int'(bus.disp_ready), 1);
    check_val("rst_cvalid", int'(bus.commit_valid), 0);
    check_val("rst_empty", int'(bus.empty), 1);
    check_val("rst_full", int'(bus.full), 0);
    check_val("rst_count", int'(bus.count), 0);
    check_val("rst_tag0", int'(bus.disp_tag[0]), 0);
    check_val("rst_tag1", int'(bus.disp_tag[1]), 1);

    // two-lane dispatch, completed out of order
    bus.disp_valid = 2'b11; bus.disp_use_rw = 2'b11;
    bus.disp_rw_addr[0] = 5'd5; bus.disp_rw_addr[1] = 5'd9;
    bus.disp_use_rs = 2'b10; bus.disp_rs_addr[1] = 4'd3;
    #1;
    check_val("d1_tag0", int'(bus.disp_tag[0]), 0);
    check_val("d1_tag1", int'(bus.disp_tag[1]), 1);
    tick(); clr(); #1;
    check_val("d1_count", int'(bus.count), 2);
    check_val("d1_empty", int'(bus.empty), 0);
    wb(2'b01, 1, 0);
    tick(); clr(); wb(2'b01, 0, 0); #1;
    check_val("ooo_hold", int'(bus.commit_valid), 0);
    tick(); clr(); #1;
    check_val("c1_valid", int'(bus.commit_valid), 3);
    check_val("c1_tag0", int'(bus.commit_tag[0]), 0);
    check_val("c1_tag1", int'(bus.commit_tag[1]), 1);
    check_val("c1_rw0", int'(bus.commit_rw_addr[0]), 5);
    check_val("c1_rw1", int'(bus.commit_rw_addr[1]), 9);
    check_val("c1_use_rs", int'(bus.commit_use_rs), 2);
    check_val("c1_rs1", int'(bus.commit_rs_addr[1]), 3);
    tick(); #1;
    check_val("c1_count", int'(bus.count), 0);

    // sparse lanes from zeroed pointers, stray writeback
    bus.flush = 1'b1;
    tick(); clr();
    bus.disp_valid = 2'b10; #1;
    check_val("sparse_tag1", int'(bus.disp_tag[1]), 0);
    tick(); clr(); wb(2'b01, 5, 0); #1;
    check_val("sparse_count", int'(bus.count), 1);
    tick(); clr(); #1;
    check_val("stray_count", int'(bus.count), 1);
    check_val("stray_cvalid", int'(bus.commit_valid), 0);
    bus.disp_valid = 2'b01; #1;
    check_val("sparse_tail", int'(bus.disp_tag[0]), 1);
    tick();

    // fill to 7, commit one while dispatch is refused
    bus.disp_valid = 2'b11; tick(); tick();
    bus.disp_valid = 2'b01; #1;
    check_val("fill_ready6", int'(bus.disp_ready), 1);
    tick(); clr(); #1;
    check_val("fill_count", int'(bus.count), 7);
    check_val("fill_ready", int'(bus.disp_ready), 0);
    check_val("fill_full", int'(bus.full), 0);
    wb(2'b01, 0, 0);
    tick(); clr(); bus.disp_valid = 2'b11; #1;
    check_val("nf_cvalid", int'(bus.commit_valid), 1);
    check_val("nf_ctag", int'(bus.commit_tag[0]), 0);
    check_val("nf_ready", int'(bus.disp_ready), 0);
    tick(); clr(); #1;
    check_val("nf_count", int'(bus.count), 6);
    check_val("nf_ready_next", int'(bus.disp_ready), 1);

    // wrap: tags 7,0 allocated, drain 1..6 then retire across the wrap
    bus.disp_valid = 2'b11; #1;
    check_val("wr_tag0", int'(bus.disp_tag[0]), 7);
    check_val("wr_tag1", int'(bus.disp_tag[1]), 0);
    tick(); clr(); #1;
    check_val("wr_full", int'(bus.full), 1);
    check_val("wr_count", int'(bus.count), 8);
    wb(2'b11, 1, 2);
    tick(); clr(); wb(2'b11, 3, 4); #1;
    check_val("dr_cvalid", int'(bus.commit_valid), 3);
    check_val("dr_ctag0", int'(bus.commit_tag[0]), 1);
    check_val("dr_ready", int'(bus.disp_ready), 0);
    tick(); clr(); wb(2'b11, 5, 6); #1;
    check_val("dr_count", int'(bus.count), 6);
    tick(); clr(); wb(2'b11, 7, 0);
    tick(); clr(); #1;
    check_val("wrap_cvalid", int'(bus.commit_valid), 3);
    check_val("wrap_ctag0", int'(bus.commit_tag[0]), 7);
    check_val("wrap_ctag1", int'(bus.commit_tag[1]), 0);
    check_val("wrap_count", int'(bus.count), 2);
    tick(); #1;
    check_val("wrap_empty", int'(bus.empty), 1);

    // flush with five entries, two done
    bus.disp_valid = 2'b11; #1;
    check_val("head1_tag0", int'(bus.disp_tag[0]), 1);
    tick(); tick();
    bus.disp_valid = 2'b01; tick(); clr();
    wb(2'b11, 1, 2);
    tick(); clr(); #1;
    check_val("fl_count", int'(bus.count), 5);
    check_val("fl_pre_cvalid", int'(bus.commit_valid), 3);
    bus.flush = 1'b1; #1;
    check_val("fl_cvalid", int'(bus.commit_valid), 0);
    tick(); clr(); bus.disp_valid = 2'b11; #1;
    check_val("fl_count_after", int'(bus.count), 0);
    check_val("fl_empty", int'(bus.empty), 1);
    check_val("fl_tag0", int'(bus.disp_tag[0]), 0);
    check_val("fl_tag1", int'(bus.disp_tag[1]), 1);
    check_val("fl_cvalid_after", int'(bus.commit_valid), 0);
    tick(); clr();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
